// File: rtl/execute_pkg.sv
// Shared types for the execute stage: ALU opcodes, FSM states and the multiplier cycle count.
package execute_pkg;

    typedef enum logic [3:0] {
        OP_ADD    = 4'b0000,
        OP_SUB    = 4'b0001,
        OP_AND    = 4'b0010,
        OP_OR     = 4'b0011,
        OP_XOR    = 4'b0100,
        OP_SLT    = 4'b0101,
        OP_SLTU   = 4'b0110,
        OP_SLL    = 4'b0111,
        OP_SRL    = 4'b1000,
        OP_SRA    = 4'b1001,
        OP_PASS_B = 4'b1010,
        OP_MUL    = 4'b1100,
        OP_MULHU  = 4'b1101
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } exec_state_e;

    // MUL_CYCLES: one radix-2 step per operand bit.
    function automatic int mul_cycles(input int data_width);
        return data_width;
    endfunction

endpackage

// File: rtl/iter_multiplier.sv
// Radix-2 shift-add unsigned multiplier; only built when EXECUTE_MUL_EN is defined.
// The first partial product is folded into the start cycle so done pulses after mul_cycles()-1 more steps.
`ifdef EXECUTE_MUL_EN
module iter_multiplier
    import execute_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [DATA_WIDTH-1:0]   a,
    input  logic [DATA_WIDTH-1:0]   b,
    output logic                    done,
    output logic [2*DATA_WIDTH-1:0] product
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(mul_cycles(DATA_WIDTH) - 1);

    logic [2*DATA_WIDTH-1:0] mcand_q, prod_q;
    logic [DATA_WIDTH-1:0]   mplier_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    run_q, done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            prod_q   <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
            done_q   <= 1'b0;
        end else if (start) begin
            mcand_q  <= {{DATA_WIDTH{1'b0}}, a} << 1;
            mplier_q <= b >> 1;
            prod_q   <= b[0] ? {{DATA_WIDTH{1'b0}}, a} : '0;
            cnt_q    <= CNT_W'(1);
            run_q    <= 1'b1;
            done_q   <= 1'b0;
        end else if (run_q) begin
            prod_q   <= prod_q + (mplier_q[0] ? mcand_q : '0);
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST) begin
                run_q  <= 1'b0;
                done_q <= 1'b1;
            end
        end else begin
            done_q <= 1'b0;
        end
    end

    assign done    = done_q;
    assign product = prod_q;

endmodule
`endif

// File: rtl/execute_unit.sv
// Handshaked execute stage: single-cycle ALU with registered result/eq and rd/reg_write forwarding.
// Define EXECUTE_MUL_EN to add MUL/MULHU through the iterative iter_multiplier.
module execute_unit
    import execute_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ALUCTRL_WIDTH  = 4,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     rs1_data,
    input  logic [DATA_WIDTH-1:0]     rs2_data,
    input  logic [DATA_WIDTH-1:0]     imm_ext,
    input  logic                      alu_src,
    input  logic [ALUCTRL_WIDTH-1:0]  alu_ctrl,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr,
    input  logic                      reg_write,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     alu_result,
    output logic [DATA_WIDTH-1:0]     write_data,
    output logic                      eq,
    output logic [REG_ADDR_WIDTH-1:0] rd_addr_out,
    output logic                      reg_write_out,
    output logic                      busy
);

    localparam int SHW = $clog2(DATA_WIDTH);

    exec_state_e               state_q;
    logic                      out_valid_q, eq_q, reg_write_q;
    logic [DATA_WIDTH-1:0]     alu_result_q, write_data_q;
    logic [REG_ADDR_WIDTH-1:0] rd_addr_q;

    logic [DATA_WIDTH-1:0] op2, alu_res;
    logic                  accept, out_fire;

    assign op2      = alu_src ? imm_ext : rs2_data;
    assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready;

    always_comb begin
        alu_res = '0;
        case (alu_ctrl)
            ALUCTRL_WIDTH'(OP_ADD):    alu_res = rs1_data + op2;
            ALUCTRL_WIDTH'(OP_SUB):    alu_res = rs1_data - op2;
            ALUCTRL_WIDTH'(OP_AND):    alu_res = rs1_data & op2;
            ALUCTRL_WIDTH'(OP_OR):     alu_res = rs1_data | op2;
            ALUCTRL_WIDTH'(OP_XOR):    alu_res = rs1_data ^ op2;
            ALUCTRL_WIDTH'(OP_SLT):    alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(rs1_data) < $signed(op2))};
            ALUCTRL_WIDTH'(OP_SLTU):   alu_res = {{(DATA_WIDTH-1){1'b0}}, (rs1_data < op2)};
            ALUCTRL_WIDTH'(OP_SLL):    alu_res = rs1_data << op2[SHW-1:0];
            ALUCTRL_WIDTH'(OP_SRL):    alu_res = rs1_data >> op2[SHW-1:0];
            ALUCTRL_WIDTH'(OP_SRA):    alu_res = $unsigned($signed(rs1_data) >>> op2[SHW-1:0]);
            ALUCTRL_WIDTH'(OP_PASS_B): alu_res = op2;
            default:                   alu_res = '0;
        endcase
    end

`ifdef EXECUTE_MUL_EN
    logic                    is_mul, mul_done, mul_hi_q;
    logic [2*DATA_WIDTH-1:0] mul_prod;

    assign is_mul = (alu_ctrl == ALUCTRL_WIDTH'(OP_MUL)) || (alu_ctrl == ALUCTRL_WIDTH'(OP_MULHU));
    assign busy   = (state_q == MUL_BUSY);

    iter_multiplier #(.DATA_WIDTH(DATA_WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept && is_mul),
        .a       (rs1_data),
        .b       (op2),
        .done    (mul_done),
        .product (mul_prod)
    );
`else
    assign busy = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            out_valid_q  <= 1'b0;
            eq_q         <= 1'b0;
            reg_write_q  <= 1'b0;
            alu_result_q <= '0;
            write_data_q <= '0;
            rd_addr_q    <= '0;
`ifdef EXECUTE_MUL_EN
            mul_hi_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (out_fire) out_valid_q <= 1'b0;
                    if (accept) begin
                        // Side-band fields are captured at accept even for a multiply; out_valid stays low until done.
                        eq_q         <= (rs1_data == op2);
                        write_data_q <= rs2_data;
                        rd_addr_q    <= rd_addr;
                        reg_write_q  <= reg_write;
`ifdef EXECUTE_MUL_EN
                        if (is_mul) begin
                            mul_hi_q <= (alu_ctrl == ALUCTRL_WIDTH'(OP_MULHU));
                            state_q  <= MUL_BUSY;
                        end else begin
                            alu_result_q <= alu_res;
                            out_valid_q  <= 1'b1;
                        end
`else
                        alu_result_q <= alu_res;
                        out_valid_q  <= 1'b1;
`endif
                    end
                end
`ifdef EXECUTE_MUL_EN
                MUL_BUSY: begin
                    if (mul_done) begin
                        alu_result_q <= mul_hi_q ? mul_prod[2*DATA_WIDTH-1:DATA_WIDTH]
                                                 : mul_prod[DATA_WIDTH-1:0];
                        out_valid_q  <= 1'b1;
                        state_q      <= MUL_DONE;
                    end
                end
                MUL_DONE: begin
                    if (out_fire) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_valid     = out_valid_q;
    assign alu_result    = alu_result_q;
    assign write_data    = write_data_q;
    assign eq            = eq_q;
    assign rd_addr_out   = rd_addr_q;
    assign reg_write_out = reg_write_q;

endmodule

// File: tb/tb_execute_unit.sv
// Directed bench for execute_unit: ALU vectors, backpressure, async reset, and the optional multiplier.
module tb_execute_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, alu_src, reg_write;
    logic [31:0] rs1_data, rs2_data, imm_ext;
    logic [3:0]  alu_ctrl;
    logic [4:0]  rd_addr, rd_addr_out;
    logic        out_valid, out_ready, eq, reg_write_out, busy;
    logic [31:0] alu_result, write_data;

    int total = 0;
    int bad   = 0;

    execute_unit #(.DATA_WIDTH(32), .ALUCTRL_WIDTH(4), .REG_ADDR_WIDTH(5)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .rs1_data      (rs1_data),
        .rs2_data      (rs2_data),
        .imm_ext       (imm_ext),
        .alu_src       (alu_src),
        .alu_ctrl      (alu_ctrl),
        .rd_addr       (rd_addr),
        .reg_write     (reg_write),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .alu_result    (alu_result),
        .write_data    (write_data),
        .eq            (eq),
        .rd_addr_out   (rd_addr_out),
        .reg_write_out (reg_write_out),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge with out_ready=1; checks the registered result one cycle after accept.
    task automatic single(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] imm, input logic src, input logic [31:0] exp_res, input logic exp_eq);
        rs1_data = a; rs2_data = b; imm_ext = imm; alu_src = src; alu_ctrl = op;
        rd_addr = {1'b1, op}; reg_write = 1'b1; in_valid = 1'b1;
        #1 chk({tag, "_rdy"}, in_ready, 1);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_vld"}, out_valid, 1);
        chk({tag, "_res"}, alu_result, exp_res);
        chk({tag, "_eq"}, eq, exp_eq);
        chk({tag, "_wd"}, write_data, b);
        chk({tag, "_rd"}, rd_addr_out, {1'b1, op});
        chk({tag, "_busy"}, busy, 0);
    endtask

`ifdef EXECUTE_MUL_EN
    task automatic mul_run(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_res);
        int n = 0, busyc = 0, rdy_busy = 0;
        rs1_data = a; rs2_data = b; alu_src = 1'b0; alu_ctrl = op; in_valid = 1'b1;
        #1 chk({tag, "_rdy"}, in_ready, 1);
        @(posedge clk); #1 in_valid = 1'b0;
        rs1_data = 32'hdead_beef; rs2_data = 32'h1234_5678;
        while (n < 100) begin
            @(negedge clk); n++;
            if (busy) busyc++;
            if (busy && in_ready) rdy_busy++;
            if (out_valid) break;
        end
        chk({tag, "_lat"}, n, 33);
        chk({tag, "_busyc"}, busyc, 32);
        chk({tag, "_rdybusy"}, rdy_busy, 0);
        chk({tag, "_res"}, alu_result, exp_res);
        chk({tag, "_eq"}, eq, (a == b));
        @(negedge clk);
        chk({tag, "_idle"}, in_ready, 1);
    endtask
`endif

    initial begin
        logic [31:0] exp_b2b [4];
        logic [31:0] held = '0;
        logic        stalled = 1'b0, acc;
        int          nin = 0, nout = 0;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; alu_src = 1'b0; alu_ctrl = '0;
        rs1_data = '0; rs2_data = '0; imm_ext = '0; rd_addr = '0; reg_write = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_vld", out_valid, 0);
        chk("rst_res", alu_result, 0);
        chk("rst_rw", reg_write_out, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        #1 chk("rst_rdy", in_ready, 1);
        @(negedge clk);

        // Directed ALU vectors
        single("add_ovf", 4'h0, 32'h7fff_ffff, 32'h0000_0009, 32'h0000_0001, 1'b1, 32'h8000_0000, 1'b0);
        single("add_wrap", 4'h0, 32'hffff_ffff, 32'h0000_0001, 32'h0, 1'b0, 32'h0000_0000, 1'b0);
        single("sub_eq", 4'h1, 32'h0000_0005, 32'h0000_0005, 32'h0, 1'b0, 32'h0000_0000, 1'b1);
        single("sub_neg", 4'h1, 32'h0000_0000, 32'h0000_0001, 32'h0, 1'b0, 32'hffff_ffff, 1'b0);
        single("and", 4'h2, 32'hf0f0_f0f0, 32'hff00_ff00, 32'h0, 1'b0, 32'hf000_f000, 1'b0);
        single("or", 4'h3, 32'hf0f0_f0f0, 32'hff00_ff00, 32'h0, 1'b0, 32'hfff0_fff0, 1'b0);
        single("xor", 4'h4, 32'hf0f0_f0f0, 32'hff00_ff00, 32'h0, 1'b0, 32'h0ff0_0ff0, 1'b0);
        single("slt", 4'h5, 32'hffff_ffff, 32'h0000_0001, 32'h0, 1'b0, 32'h0000_0001, 1'b0);
        single("sltu", 4'h6, 32'h0000_0001, 32'hffff_ffff, 32'h0, 1'b0, 32'h0000_0001, 1'b0);
        single("sll31", 4'h7, 32'h0000_0001, 32'h0000_001f, 32'h0, 1'b0, 32'h8000_0000, 1'b0);
        single("sll_mask", 4'h7, 32'h0000_0001, 32'h0000_0024, 32'h0, 1'b0, 32'h0000_0010, 1'b0);
        single("srl", 4'h8, 32'h8000_0000, 32'h0000_0004, 32'h0, 1'b0, 32'h0800_0000, 1'b0);
        single("sra", 4'h9, 32'h8000_0000, 32'h0000_0004, 32'h0, 1'b0, 32'hf800_0000, 1'b0);
        single("pass_b", 4'ha, 32'h0000_0000, 32'h0000_0009, 32'h0000_1234, 1'b1, 32'h0000_1234, 1'b0);
        single("unused_f", 4'hf, 32'h0000_0003, 32'h0000_0003, 32'h0, 1'b0, 32'h0000_0000, 1'b1);
`ifndef EXECUTE_MUL_EN
        single("nomul_c", 4'hc, 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b0, 32'h0000_0000, 1'b1);
        single("nomul_d", 4'hd, 32'h0000_0007, 32'h0000_0002, 32'h0, 1'b0, 32'h0000_0000, 1'b0);
`endif
        @(negedge clk);
        chk("drain", out_valid, 0);

        // Back-to-back with 3 cycles of output stall after the first result
        for (int i = 0; i < 4; i++) exp_b2b[i] = 32'(i + 1) + 32'h10;
        alu_ctrl = 4'h0; alu_src = 1'b0; rs2_data = 32'h10; rs1_data = 32'd1; in_valid = 1'b1;
        for (int cyc = 0; cyc < 30 && nout < 4; cyc++) begin
            out_ready = !(cyc >= 1 && cyc <= 3);
            #1;
            if (out_valid) begin
                if (stalled) chk("b2b_hold", alu_result, held);
                if (out_ready) begin
                    chk("b2b_res", alu_result, exp_b2b[nout]);
                    nout++;
                    stalled = 1'b0;
                end else begin
                    chk("b2b_stall_rdy", in_ready, 0);
                    held = alu_result;
                    stalled = 1'b1;
                end
            end
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) begin
                nin++;
                if (nin < 4) rs1_data = 32'(nin + 1);
                else in_valid = 1'b0;
            end
            @(negedge clk);
        end
        chk("b2b_count", nout, 4);
        chk("b2b_in", nin, 4);
        out_ready = 1'b1;
        @(negedge clk);

        // Async reset while a result is being held
        out_ready = 1'b0;
        rs1_data = 32'h0000_0011; rs2_data = 32'h0000_0022; alu_ctrl = 4'h0; rd_addr = 5'd7; reg_write = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        chk("mid_vld", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", out_valid, 0);
        chk("mid_rst_res", alu_result, 0);
        chk("mid_rst_wd", write_data, 0);
        chk("mid_rst_rd", rd_addr_out, 0);
        chk("mid_rst_rw", reg_write_out, 0);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        #1 chk("mid_rst_rdy", in_ready, 1);
        @(negedge clk);

`ifdef EXECUTE_MUL_EN
        mul_run("mul_lo", 4'hc, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000);
        mul_run("mul_hi", 4'hd, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001);
        mul_run("mul_small", 4'hc, 32'h0000_0007, 32'h0000_0006, 32'h0000_002a);
        mul_run("mulhu_max", 4'hd, 32'hffff_ffff, 32'hffff_ffff, 32'hffff_fffe);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
